// File: rtl/ndn_pkt_pkg.sv
// Shared packet definitions for the NDN to MCU transmit path:
// packet types, field widths, header layout and the framer state encoding.
package ndn_pkt_pkg;

  localparam logic PKT_INTEREST = 1'b1;
  localparam logic PKT_DATA     = 1'b0;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;

  // Header byte layout: {reserved(0), type, len}
  localparam int HDR_LEN_LSB  = 0;
  localparam int HDR_TYPE_BIT = 6;
  localparam int HDR_RSVD_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PREFIX,
    PAYLOAD,
    DONE
  } state_e;

  function automatic logic [7:0] make_header(input logic pkt_type, input logic [LEN_W-1:0] len);
    return {1'b0, pkt_type, len};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to rr_ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] winner
);

  always_comb begin
    winner = req;
    if (req == 2'b11) begin
      winner = rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mcu_tx_arbiter.sv
// Shares the SPI transmit byte path between the PIT (source 0, data packets) and
// the FIB path (source 1, interest packets); frames header, prefix and payload bytes.
module mcu_tx_arbiter
  import ndn_pkt_pkg::*;
#(
  parameter int PREFIX_BYTES  = 8,
  parameter int PAYLOAD_BYTES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic                type0,
  input  logic                type1,
  input  logic [LEN_W-1:0]    len0,
  input  logic [LEN_W-1:0]    len1,
  input  logic [PREFIX_W-1:0] prefix0,
  input  logic [PREFIX_W-1:0] prefix1,
  input  logic                pay_valid0,
  input  logic                pay_valid1,
  input  logic [7:0]          pay_byte0,
  input  logic [7:0]          pay_byte1,
  output logic                pay_ready0,
  output logic                pay_ready1,
  output logic                grant0,
  output logic                grant1,
  output logic                done0,
  output logic                done1,
  output logic                tx_valid,
  output logic [7:0]          tx_byte,
  output logic                tx_last,
  input  logic                tx_ready
);

  localparam int CNT_MAX = (PREFIX_BYTES > PAYLOAD_BYTES) ? PREFIX_BYTES : PAYLOAD_BYTES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] PREFIX_LAST  = CNT_W'(PREFIX_BYTES - 1);
  localparam logic [CNT_W-1:0] PAYLOAD_LAST = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e              state_reg;
  logic [1:0]          grant_reg;
  logic [1:0]          done_reg;
  logic                rr_ptr_reg;
  logic [7:0]          header_reg;
  logic [PREFIX_W-1:0] prefix_reg;
  logic [CNT_W-1:0]    byte_cnt_reg;

  logic [1:0] req_vec;
  logic [1:0] win;
  logic [1:0] pay_ready_vec;
  logic       sel;
  logic       pay_valid_sel;
  logic [7:0] pay_byte_sel;
  logic       is_interest;
  logic       cnt_zero;
  logic       xfer;

  assign req_vec = {req1, req0};

  rr_arb2 u_arb (
    .req    (req_vec),
    .rr_ptr (rr_ptr_reg),
    .winner (win)
  );

  assign sel           = grant_reg[1];
  assign pay_valid_sel = sel ? pay_valid1 : pay_valid0;
  assign pay_byte_sel  = sel ? pay_byte1 : pay_byte0;
  assign is_interest   = (header_reg[HDR_TYPE_BIT] == PKT_INTEREST);
  assign cnt_zero      = (byte_cnt_reg == '0);
  assign xfer          = tx_valid && tx_ready;

  // Byte-path outputs decode from the framer state; payload is a direct
  // pass-through so the requester sees tx_ready with no added latency.
  always_comb begin
    tx_valid      = 1'b0;
    tx_byte       = 8'h00;
    tx_last       = 1'b0;
    pay_ready_vec = 2'b00;
    unique case (state_reg)
      HDR: begin
        tx_valid = 1'b1;
        tx_byte  = header_reg;
      end
      PREFIX: begin
        tx_valid = 1'b1;
        tx_byte  = prefix_reg[8*byte_cnt_reg +: 8];
        tx_last  = is_interest && cnt_zero;
      end
      PAYLOAD: begin
        tx_valid      = pay_valid_sel;
        tx_byte       = pay_byte_sel;
        tx_last       = cnt_zero;
        pay_ready_vec = sel ? {tx_ready, 1'b0} : {1'b0, tx_ready};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      grant_reg    <= 2'b00;
      done_reg     <= 2'b00;
      rr_ptr_reg   <= 1'b0;
      header_reg   <= 8'h00;
      prefix_reg   <= '0;
      byte_cnt_reg <= '0;
    end else begin
      done_reg <= 2'b00;
      unique case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            grant_reg  <= win;
            header_reg <= win[1] ? make_header(type1, len1) : make_header(type0, len0);
            prefix_reg <= win[1] ? prefix1 : prefix0;
            state_reg  <= HDR;
          end
        end
        HDR: begin
          if (xfer) begin
            byte_cnt_reg <= PREFIX_LAST;
            state_reg    <= PREFIX;
          end
        end
        PREFIX: begin
          if (xfer) begin
            if (!cnt_zero) begin
              byte_cnt_reg <= byte_cnt_reg - CNT_ONE;
            end else if (is_interest) begin
              done_reg  <= grant_reg;
              state_reg <= DONE;
            end else begin
              byte_cnt_reg <= PAYLOAD_LAST;
              state_reg    <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            if (cnt_zero) begin
              done_reg  <= grant_reg;
              state_reg <= DONE;
            end else begin
              byte_cnt_reg <= byte_cnt_reg - CNT_ONE;
            end
          end
        end
        DONE: begin
          // Hand priority to the other source so continuous requests alternate.
          grant_reg  <= 2'b00;
          rr_ptr_reg <= ~grant_reg[1];
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pay_ready0 = pay_ready_vec[0];
  assign pay_ready1 = pay_ready_vec[1];
  assign grant0     = grant_reg[0];
  assign grant1     = grant_reg[1];
  assign done0      = done_reg[0];
  assign done1      = done_reg[1];

endmodule

// File: tb/tb_mcu_tx_arbiter.sv
// Scoreboard bench for mcu_tx_arbiter: source drivers, a packet-level reference
// model that predicts winners and byte streams, and a decoupled monitor.
module tb_mcu_tx_arbiter;

  typedef struct packed {
    logic         t;
    logic [5:0]   len;
    logic [63:0]  prefix;
    logic [255:0] pay;
    logic         hold;
    logic [7:0]   delay;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_v;
  logic [1:0]  type_v;
  logic [5:0]  len_v [2];
  logic [63:0] prefix_v [2];
  logic [1:0]  pay_valid_v;
  logic [7:0]  pay_byte_v [2];
  logic        tx_ready;
  logic        pay_ready0, pay_ready1, grant0, grant1, done0, done1;
  logic        tx_valid, tx_last;
  logic [7:0]  tx_byte;

  mcu_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req_v[0]), .req1(req_v[1]),
    .type0(type_v[0]), .type1(type_v[1]),
    .len0(len_v[0]), .len1(len_v[1]),
    .prefix0(prefix_v[0]), .prefix1(prefix_v[1]),
    .pay_valid0(pay_valid_v[0]), .pay_valid1(pay_valid_v[1]),
    .pay_byte0(pay_byte_v[0]), .pay_byte1(pay_byte_v[1]),
    .pay_ready0(pay_ready0), .pay_ready1(pay_ready1),
    .grant0(grant0), .grant1(grant1),
    .done0(done0), .done1(done1),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_last(tx_last),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  desc_t drv_q [2][$];
  desc_t mdl_q [2][$];
  desc_t cur [2];
  int    phase [2];
  int    pay_idx [2];
  logic  stall_mode = 1'b0;
  int    gap_pct = 0;

  logic [1:0] grant_obs = 2'b00, acc_obs = 2'b00, done_obs = 2'b00;

  logic [8:0] exp_q [$];
  int   grant_log [$];
  logic active = 1'b0;
  logic is_data = 1'b0;
  int   winner = 0;
  int   sent = 0;
  int   pay_sent = 0;
  logic rr_mdl = 1'b0;
  logic [1:0] prev_grant = 2'b00, prev_req = 2'b00;
  logic prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  int   cyc = 0;
  int   idle_chk = -10;
  logic idle_req = 1'b0;
  int   done_cyc [2];
  int   rise_cyc [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/empty, expected event (cycle %0d)", name, cyc);
  endtask

  function automatic desc_t rand_desc(input logic hold, input logic [7:0] delay);
    desc_t d;
    d.t      = 1'($urandom_range(0, 1));
    d.len    = 6'($urandom);
    d.prefix = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) d.pay[32*i +: 32] = $urandom;
    d.hold  = hold;
    d.delay = delay;
    return d;
  endfunction

  task automatic push_pkt(input int s, input desc_t d);
    drv_q[s].push_back(d);
    mdl_q[s].push_back(d);
  endtask

  // Reference packet: header {0,type,len}, prefix MSB first, 32 payload bytes for data.
  task automatic build_exp(input desc_t d);
    logic [63:0] sh;
    logic [7:0]  hdr;
    exp_q.delete();
    hdr = 8'(d.t) * 8'd64 + 8'(d.len);
    exp_q.push_back({1'b0, hdr});
    for (int i = 0; i < 8; i++) begin
      sh = d.prefix >> (8 * (7 - i));
      exp_q.push_back({(d.t == 1'b1) && (i == 7), sh[7:0]});
    end
    if (d.t == 1'b0) begin
      for (int i = 0; i < 32; i++) exp_q.push_back({i == 31, d.pay[8*i +: 8]});
    end
  endtask

  // Source drivers: request, hold or drop req after grant, stream payload with gaps.
  initial begin
    req_v = '0; type_v = '0; pay_valid_v = '0; tx_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      len_v[s] = '0; prefix_v[s] = '0; pay_byte_v[s] = '0; phase[s] = 0; pay_idx[s] = 0;
    end
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        req_v = '0; pay_valid_v = '0; tx_ready = 1'b1; phase[0] = 0; phase[1] = 0;
      end else begin
        tx_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int s = 0; s < 2; s++) begin
          if (phase[s] == 2) begin
            if (acc_obs[s]) begin
              pay_idx[s]++;
              pay_valid_v[s] = 1'b0;
            end
            if (done_obs[s]) begin
              phase[s] = 0; req_v[s] = 1'b0; pay_valid_v[s] = 1'b0;
            end else if (cur[s].t == 1'b0 && pay_idx[s] < 32 && !pay_valid_v[s]) begin
              if ($urandom_range(0, 99) >= gap_pct) begin
                pay_valid_v[s] = 1'b1;
                pay_byte_v[s]  = cur[s].pay[8*pay_idx[s] +: 8];
              end
            end
          end
          if (phase[s] == 1 && grant_obs[s]) begin
            phase[s] = 2; pay_idx[s] = 0;
            if (!cur[s].hold) begin
              req_v[s] = 1'b0; type_v[s] = 1'($urandom);
              len_v[s] = 6'($urandom); prefix_v[s] = {$urandom, $urandom};
            end
          end
          if (phase[s] == 0 && drv_q[s].size() > 0) begin
            if (drv_q[s][0].delay != 8'd0) begin
              drv_q[s][0].delay = drv_q[s][0].delay - 8'd1;
            end else begin
              cur[s] = drv_q[s].pop_front();
              phase[s] = 1; req_v[s] = 1'b1; type_v[s] = cur[s].t;
              len_v[s] = cur[s].len; prefix_v[s] = cur[s].prefix; pay_valid_v[s] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [1:0] g, d, exp_pr;
    logic       ev;
    logic [8:0] e;
    int         w;
    desc_t      md;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        exp_q.delete(); active = 1'b0; rr_mdl = 1'b0; prev_grant = '0; prev_req = '0;
        prev_stall = 1'b0; pay_sent = 0; sent = 0; idle_chk = -10;
        grant_obs = '0; acc_obs = '0; done_obs = '0;
      end else begin
        g = {grant1, grant0};
        if (prev_grant == 2'b00 && g != 2'b00) begin
          if (prev_req == 2'b00) w = -1;
          else if (prev_req == 2'b11) w = int'(rr_mdl);
          else w = prev_req[1] ? 1 : 0;
          chk("grant_winner", 64'(g), (w < 0) ? 64'd0 : (64'd1 << w));
          if (w >= 0) begin
            if (mdl_q[w].size() == 0) fail_now("model_queue");
            else begin
              md = mdl_q[w].pop_front();
              build_exp(md);
              is_data = (md.t == 1'b0); winner = w; active = 1'b1;
              sent = 0; pay_sent = 0; grant_log.push_back(w); rise_cyc[w] = cyc;
            end
          end
        end
        if (cyc == idle_chk + 1) chk("rearb_gap", 64'(g != 2'b00), 64'(idle_req));
        if (cyc == idle_chk) idle_req = |req_v;

        ev = active && exp_q.size() > 0 && ((sent < 9) ? 1'b1 : pay_valid_v[winner]);
        chk("tx_valid", 64'(tx_valid), 64'(ev));
        exp_pr = 2'b00;
        if (active && is_data && sent >= 9 && exp_q.size() > 0) exp_pr[winner] = tx_ready;
        chk("pay_ready", 64'({pay_ready1, pay_ready0}), 64'(exp_pr));
        if (prev_stall) chk("stall_hold", 64'({tx_valid, tx_byte}), 64'({1'b1, prev_byte}));

        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_byte");
          else begin
            e = exp_q.pop_front();
            chk("tx_byte_last", 64'({tx_last, tx_byte}), 64'(e));
            sent++;
            if (is_data && sent > 9) pay_sent++;
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_byte  = tx_byte;

        d = {done1, done0};
        if (d != 2'b00) begin
          chk("done_pulse", 64'({active, d, exp_q.size() == 0}),
              64'({1'b1, (2'b01 << winner), 1'b1}));
          rr_mdl = (winner == 0);
          active = 1'b0; idle_chk = cyc + 1; done_cyc[winner] = cyc;
        end
        prev_grant = g; prev_req = req_v; grant_obs = g;
        acc_obs = pay_valid_v & {pay_ready1, pay_ready0}; done_obs = d;
      end
    end
  end

  task automatic wait_quiet(input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(drv_q[0].size() == 0 && drv_q[1].size() == 0 && phase[0] == 0 &&
                 phase[1] == 0 && !active) && n < max_cyc);
    if (n >= max_cyc) fail_now("quiet_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
  endtask

  initial begin
    desc_t d;
    int    n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({tx_valid, tx_byte, tx_last, grant1, grant0, done1, done0,
                              pay_ready1, pay_ready0}), 64'd0);
    @(posedge clk); #3 rst = 1'b1;

    // Interest packet from source 1.
    d = '0; d.t = 1'b1; d.len = 6'h0A; d.prefix = 64'h0102030405060708;
    push_pkt(1, d);
    wait_quiet(200);

    // Data packet from source 0 with an incrementing payload.
    d = '0; d.prefix = 64'hAABBCCDDEEFF0011;
    for (int i = 0; i < 32; i++) d.pay[8*i +: 8] = 8'(i);
    push_pkt(0, d);
    wait_quiet(300);

    // Both sources requesting continuously from reset: grants alternate.
    pulse_reset();
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      push_pkt(0, rand_desc(1'b1, 8'd0));
      push_pkt(1, rand_desc(1'b1, 8'd0));
    end
    wait_quiet(1000);
    chk("grant_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < grant_log.size(); i++) chk("grant_order", 64'(grant_log[i]), 64'(i % 2));

    // Stalled data packet: tx_ready toggling plus payload gaps.
    stall_mode = 1'b1; gap_pct = 40;
    d = rand_desc(1'b0, 8'd0); d.t = 1'b0;
    push_pkt(1, d);
    wait_quiet(2000);

    // Randomized mix of sources, types, delays, holds, stalls.
    for (int i = 0; i < 16; i++)
      push_pkt($urandom_range(0, 1), rand_desc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 6))));
    wait_quiet(8000);
    stall_mode = 1'b0; gap_pct = 0;

    // Reset during payload byte 10, then both pending: source 0 must win.
    d = rand_desc(1'b0, 8'd0); d.t = 1'b0;
    push_pkt(0, d);
    n = 0;
    while (!(active && pay_sent == 10) && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 500) fail_now("reach_payload10");
    rst = 1'b0;
    #1;
    chk("midpkt_reset_outputs", 64'({tx_valid, tx_byte, tx_last, grant1, grant0, done1, done0,
                                     pay_ready1, pay_ready0}), 64'd0);
    @(posedge clk); #3;
    drv_q[0].delete(); drv_q[1].delete(); mdl_q[0].delete(); mdl_q[1].delete();
    push_pkt(1, rand_desc(1'b0, 8'd0));
    push_pkt(0, rand_desc(1'b0, 8'd0));
    @(posedge clk); #3 rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(grant0 || grant1) && n < 20);
    chk("post_reset_winner", 64'({grant1, grant0}), 64'b01);
    wait_quiet(500);

    // Source 1 requests during source 0's payload: grant1 two cycles after done0.
    d = rand_desc(1'b0, 8'd0); d.t = 1'b0;
    push_pkt(0, d);
    push_pkt(1, rand_desc(1'b0, 8'd25));
    wait_quiet(500);
    chk("grant1_after_done0", 64'(rise_cyc[1] - done_cyc[0]), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected end of test before 900000");
    $fatal(1, "watchdog expired");
  end

endmodule
